// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: measures the hs/vs periods, recognises 640x480, 800x600 and 1024x768,
// locks after a run of stable frames and passes active-area pixels through with coordinates.
//
// state     | meaning
// NO_SIGNAL | no usable timing yet, or a line outlived the 11-bit counter
// MEASURE   | counting consecutive identical, known frames toward lock
// LOCKED    | timing recognised; active-area pixels are forwarded
module vga_sync_receiver #(
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [3:0]  in_r,
   input  logic [3:0]  in_g,
   input  logic [3:0]  in_b,
   output logic [3:0]  out_r,
   output logic [3:0]  out_g,
   output logic [3:0]  out_b,
   output logic        pixel_valid,
   output logic [10:0] x_pos,
   output logic [10:0] y_pos,
   output logic        locked,
   output logic [1:0]  resolution,
   output logic [10:0] h_total,
   output logic [10:0] v_total
);

   typedef enum logic [1:0] {NO_SIGNAL, MEASURE, LOCKED} state_t;

   localparam logic [10:0] CNT_MAX = 11'd2047;
   localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

   state_t      state;
   logic        hs_q;
   logic        vs_q;
   logic        vs_pending;
   logic [10:0] hcnt;
   logic [10:0] line_cnt;
   logic [2:0]  match_cnt;
   logic [10:0] prev_h;
   logic [10:0] prev_v;

   logic        hs_start;
   logic        vs_start;
   logic        frame_done;
   logic        timeout;
   logic [10:0] h_meas;
   logic [10:0] v_meas;
   logic [1:0]  meas_mode;
   logic        pair_same;
   logic [2:0]  match_inc;
   logic        geo_ok;
   logic [10:0] x0;
   logic [10:0] x_end;
   logic [10:0] y0;
   logic [10:0] y_end;
   logic        in_active;

   assign hs_start   = hs_q & ~h_sync;
   assign vs_start   = vs_q & ~v_sync;
   assign frame_done = hs_start & (vs_pending | vs_start);
   // hcnt about to reach its ceiling with no line start in sight
   assign timeout    = ~hs_start & (hcnt >= 11'd2046);
   assign h_meas     = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1;
   assign v_meas     = (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + 11'd1;
   assign pair_same  = (h_meas == prev_h) && (v_meas == prev_v);
   assign match_inc  = match_cnt + 3'd1;

   always_comb begin
      meas_mode = 2'b11;
      if (h_meas == 11'd800 && v_meas == 11'd525)
         meas_mode = 2'b00;
      else if (h_meas == 11'd1056 && v_meas == 11'd628)
         meas_mode = 2'b01;
      else if (h_meas == 11'd1344 && v_meas == 11'd806)
         meas_mode = 2'b10;
   end

   always_comb begin
      geo_ok = 1'b1;
      x0     = 11'd0;
      x_end  = 11'd0;
      y0     = 11'd0;
      y_end  = 11'd0;
      case (resolution)
         2'b00: begin x0 = 11'd144; x_end = 11'd783;  y0 = 11'd35; y_end = 11'd514; end
         2'b01: begin x0 = 11'd216; x_end = 11'd1015; y0 = 11'd27; y_end = 11'd626; end
         2'b10: begin x0 = 11'd296; x_end = 11'd1319; y0 = 11'd35; y_end = 11'd802; end
         default: geo_ok = 1'b0;
      endcase
   end

   assign in_active = locked && geo_ok &&
                      (hcnt >= x0) && (hcnt <= x_end) &&
                      (line_cnt >= y0) && (line_cnt <= y_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         hcnt       <= '0;
         line_cnt   <= '0;
         vs_pending <= 1'b0;
         h_total    <= '0;
         v_total    <= '0;
      end else begin
         hs_q <= h_sync;
         vs_q <= v_sync;
         if (hs_start) begin
            hcnt    <= '0;
            h_total <= h_meas;
         end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + 11'd1;
         end
         if (frame_done) begin
            v_total    <= v_meas;
            line_cnt   <= '0;
            vs_pending <= 1'b0;
         end else begin
            if (hs_start && line_cnt != CNT_MAX)
               line_cnt <= line_cnt + 11'd1;
            if (vs_start)
               vs_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= NO_SIGNAL;
         match_cnt  <= '0;
         locked     <= 1'b0;
         resolution <= 2'b11;
         prev_h     <= '0;
         prev_v     <= '0;
      end else if (timeout) begin
         state      <= NO_SIGNAL;
         match_cnt  <= '0;
         locked     <= 1'b0;
         resolution <= 2'b11;
      end else if (frame_done) begin
         prev_h <= h_meas;
         prev_v <= v_meas;
         case (state)
            NO_SIGNAL: begin
               // the frame that brought us here may be partial, so it never counts
               state     <= MEASURE;
               match_cnt <= '0;
            end
            MEASURE: begin
               if (meas_mode != 2'b11 && (match_cnt == 3'd0 || pair_same)) begin
                  match_cnt <= match_inc;
                  if (match_inc == LOCK_N) begin
                     state      <= LOCKED;
                     locked     <= 1'b1;
                     resolution <= meas_mode;
                  end
               end else begin
                  match_cnt <= '0;
               end
            end
            LOCKED: begin
               if (!pair_same) begin
                  state      <= MEASURE;
                  locked     <= 1'b0;
                  resolution <= 2'b11;
                  match_cnt  <= '0;
               end
            end
            default: state <= NO_SIGNAL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_valid <= 1'b0;
         out_r       <= '0;
         out_g       <= '0;
         out_b       <= '0;
         x_pos       <= '0;
         y_pos       <= '0;
      end else if (in_active) begin
         pixel_valid <= 1'b1;
         out_r       <= in_r;
         out_g       <= in_g;
         out_b       <= in_b;
         x_pos       <= hcnt - x0;
         y_pos       <= line_cnt - y0;
      end else begin
         pixel_valid <= 1'b0;
         out_r       <= '0;
         out_g       <= '0;
         out_b       <= '0;
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: real VGA frame timing, lock/unlock, pixel path,
// line timeout, mid-frame reset and a non-standard mode.
module tb_vga_sync_receiver;

   localparam int F640  = 800 * 525;
   localparam int F1024 = 1344 * 806;
   localparam int F900  = 900 * 500;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        h_sync;
   logic        v_sync;
   logic [3:0]  in_r;
   logic [3:0]  in_g;
   logic [3:0]  in_b;
   logic [3:0]  out_r;
   logic [3:0]  out_g;
   logic [3:0]  out_b;
   logic        pixel_valid;
   logic [10:0] x_pos;
   logic [10:0] y_pos;
   logic        locked;
   logic [1:0]  resolution;
   logic [10:0] h_total;
   logic [10:0] v_total;

   int n_checks = 0;
   int n_errors = 0;

   int h_tot, h_sw, v_tot, v_sw;
   int tb_h, tb_v;
   bit hs_hold;

   int vld_cnt, line35_cnt, bad_cnt;
   bit seen_first;
   int first_h, first_v, first_x, first_y, first_r;

   vga_sync_receiver #(.LOCK_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .in_r        (in_r),
      .in_g        (in_g),
      .in_b        (in_b),
      .out_r       (out_r),
      .out_g       (out_g),
      .out_b       (out_b),
      .pixel_valid (pixel_valid),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .locked      (locked),
      .resolution  (resolution),
      .h_total     (h_total),
      .v_total     (v_total)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // in_r carries the receiver's expected hcnt[3:0], in_g carries (line - 35)[3:0]
   task automatic tick();
      logic [10:0] hm;
      logic [10:0] ym;
      int sh, sv;
      h_sync = hs_hold ? 1'b1 : ((tb_h >= h_sw) ? 1'b1 : 1'b0);
      v_sync = (tb_v >= v_sw) ? 1'b1 : 1'b0;
      hm = (tb_h == 0) ? 11'(h_tot - 1) : 11'(tb_h - 1);
      ym = 11'(tb_v - 35);
      in_r = hm[3:0];
      in_g = ym[3:0];
      in_b = 4'hA;
      sh = tb_h;
      sv = tb_v;
      @(posedge clk);
      #1;
      if (pixel_valid) begin
         vld_cnt++;
         if (sv == 35) line35_cnt++;
         if (!seen_first) begin
            seen_first = 1'b1;
            first_h = sh;
            first_v = sv;
            first_x = int'(x_pos);
            first_y = int'(y_pos);
            first_r = int'(out_r);
         end
         if (out_r != x_pos[3:0] || out_g != y_pos[3:0] || out_b != 4'hA) bad_cnt++;
      end else if ({out_r, out_g, out_b} != 12'h000) begin
         bad_cnt++;
      end
      tb_h++;
      if (tb_h == h_tot) begin
         tb_h = 0;
         tb_v++;
         if (tb_v == v_tot) tb_v = 0;
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic set_mode(input int ht, input int hs, input int vt, input int vs);
      h_tot = ht;
      h_sw  = hs;
      v_tot = vt;
      v_sw  = vs;
      tb_h  = 0;
      tb_v  = 0;
   endtask

   task automatic idle(input int n);
      h_sync = 1'b1;
      v_sync = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      vld_cnt    = 0;
      line35_cnt = 0;
      bad_cnt    = 0;
      seen_first = 1'b0;
      first_h = -1; first_v = -1; first_x = -1; first_y = -1; first_r = -1;
   endtask

   initial begin
      rst_n = 1'b0;
      h_sync = 1'b1;
      v_sync = 1'b1;
      in_r = '0; in_g = '0; in_b = '0;
      hs_hold = 1'b0;
      set_mode(800, 96, 525, 2);
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked", int'(locked), 0);
      check("rst_res", int'(resolution), 3);
      check("rst_valid", int'(pixel_valid), 0);
      check("rst_h_total", int'(h_total), 0);
      check("rst_v_total", int'(v_total), 0);
      check("rst_pos", int'({x_pos, y_pos}), 0);

      // 640x480: boundaries 1 and 2 do not lock, boundary 3 does
      rst_n = 1'b1;
      idle(5);
      set_mode(800, 96, 525, 2);
      run_cycles(2 * F640);
      check("lock_b2_locked", int'(locked), 0);
      check("b2_h_total", int'(h_total), 800);
      check("b2_v_total", int'(v_total), 525);
      clear_mon();
      run_cycles(1);
      check("lock_b3_locked", int'(locked), 1);
      check("lock_b3_res", int'(resolution), 0);
      check("lock_b3_h_total", int'(h_total), 800);
      check("lock_b3_v_total", int'(v_total), 525);
      run_cycles(F640 - 1);
      check("first_valid_hsample", first_h, 145);
      check("first_valid_line", first_v, 35);
      check("first_x_pos", first_x, 0);
      check("first_y_pos", first_y, 0);
      check("first_out_r", first_r, 0);
      check("valid_line35", line35_cnt, 640);
      check("valid_frame", vld_cnt, 640 * 480);
      check("pixel_data_errs", bad_cnt, 0);
      check("hold_x_pos", int'(x_pos), 639);
      check("hold_y_pos", int'(y_pos), 479);

      // asynchronous reset in the middle of an active line
      run_cycles(100 * 800 + 400);
      check("pre_rst_valid", int'(pixel_valid), 1);
      rst_n = 1'b0;
      #1;
      check("arst_locked", int'(locked), 0);
      check("arst_res", int'(resolution), 3);
      check("arst_valid", int'(pixel_valid), 0);
      check("arst_rgb", int'({out_r, out_g, out_b}), 0);
      check("arst_pos", int'({x_pos, y_pos}), 0);
      check("arst_totals", int'({h_total, v_total}), 0);
      run_cycles(3);
      rst_n = 1'b1;
      run_cycles(F640 - (100 * 800 + 400) - 3);
      run_cycles(1);
      check("relock_b1", int'(locked), 0);
      run_cycles(F640 - 1);
      run_cycles(1);
      check("relock_b2", int'(locked), 0);
      run_cycles(F640 - 1);

      // switch to 1024x768; the first boundary still measures a 640x480 frame
      set_mode(1344, 136, 806, 6);
      run_cycles(1);
      check("relock_b3_locked", int'(locked), 1);
      check("relock_b3_res", int'(resolution), 0);
      run_cycles(F1024 - 1);
      run_cycles(1);
      check("switch_unlock", int'(locked), 0);
      check("switch_unlock_res", int'(resolution), 3);
      run_cycles(F1024 - 1);
      run_cycles(1);
      check("switch_b2_locked", int'(locked), 0);
      run_cycles(F1024 - 1);
      run_cycles(1);
      check("switch_lock", int'(locked), 1);
      check("switch_lock_res", int'(resolution), 2);
      check("switch_h_total", int'(h_total), 1344);
      check("switch_v_total", int'(v_total), 806);

      // h_sync stuck high: timeout as hcnt reaches 2047
      hs_hold = 1'b1;
      clear_mon();
      run_cycles(2046);
      check("timeout_before", int'(locked), 1);
      run_cycles(1);
      check("timeout_locked", int'(locked), 0);
      check("timeout_res", int'(resolution), 3);
      clear_mon();
      run_cycles(53);
      check("timeout_no_valid", vld_cnt, 0);
      hs_hold = 1'b0;

      // non-table timing never locks
      idle(4);
      set_mode(900, 100, 500, 2);
      clear_mon();
      run_cycles(2 * F900);
      run_cycles(1);
      check("odd_locked", int'(locked), 0);
      check("odd_res", int'(resolution), 3);
      check("odd_h_total", int'(h_total), 900);
      check("odd_v_total", int'(v_total), 500);
      check("odd_no_valid", vld_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
